instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter DEPTH, default 64: number of instruction words writable before full.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000: byte address of the first written word.
REQ-003 Port clk, input, 1: the block's only clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port in_valid, input, 1: an instruction request is present.
REQ-006 Port in_ready, output, 1: the block can accept a request this cycle.
REQ-007 Port op_class, input, 3: 0 R, 1 LOAD, 2 OPIMM, 3 STORE, 4 BRANCH, 5 JAL, 6-7 illegal.
REQ-008 Ports funct3 (3), funct7 (7), rd (5), rs1 (5), rs2 (5), inputs: instruction fields.
REQ-009 Port imm, input, 21: signed immediate (byte offset for BRANCH/JAL).
REQ-010 Port start, input, 1: rewind the write pointer to BASE_ADDR and clear status.
REQ-011 Port imem_we, output, 1: instruction memory write strobe.
REQ-012 Port imem_addr, output, 32: byte write address.
REQ-013 Port imem_wdata, output, 32: encoded RV32I word.
REQ-014 Port count, output, $clog2(DEPTH+1): number of words written.
REQ-015 Port full, output, 1: high when count==DEPTH.
REQ-016 Port err, output, 1: sticky flag for a rejected request.

Function
REQ-017 Opcode per class: R 0110011, LOAD 0000011, OPIMM 0010011, STORE 0100011, BRANCH 1100011, JAL 1101111.
REQ-018 Immediate layout per class: R uses funct7/rs2; LOAD/OPIMM use I-format imm[11:0]; STORE uses S-format; BRANCH uses B-format imm[12:1]; JAL uses J-format imm[20:1]; unused fields are zero.
REQ-019 FSM states: IDLE, WRITE, FULL.
REQ-020 IDLE: in_ready=1 unless start=1. A handshake (in_valid&&in_ready) with a legal request registers the word and moves to WRITE.
REQ-021 WRITE: held for exactly one cycle with imem_we=1, in_ready=0, imem_addr=BASE_ADDR+4*count and imem_wdata=registered word.
REQ-022 Leaving WRITE, count increments. The next state is FULL if the new count==DEPTH, otherwise IDLE.
REQ-023 Latency is 1 cycle from handshake to write, so throughput is one word per 2 cycles.
REQ-024 FULL: in_ready=0 and imem_we=0, held until start or reset.
REQ-025 An illegal op_class is consumed by the handshake, sets err, and writes nothing. The FSM stays in IDLE and count is unchanged.
REQ-026 start=1 in IDLE or FULL: count=0, err=0, next state IDLE. A simultaneous in_valid is not accepted.
REQ-027 start=1 in WRITE: the write completes, then the rewind is applied the following cycle.
REQ-028 imem_addr wraps modulo 2^32; this is not treated as an error.

Reset
REQ-029 On reset=1 at a clock edge: state=IDLE, imem_we=0, imem_wdata=0, count=0, full=0, err=0, and imem_addr shows BASE_ADDR.
REQ-030 Reset during WRITE aborts the write; imem_we is 0 in the following cycle.

Configuration
REQ-031 Macro ENCODER_RANGE_CHECK_EN defined: a request is rejected (err set, no write) in any of these cases:
- I/S imm outside -2048..2047;
- BRANCH imm outside -4096..4094;
- BRANCH or JAL imm[0]=1.
REQ-032 ENCODER_RANGE_CHECK_EN undefined: the immediate is silently truncated to the format width, imm[0] is ignored, and only an illegal op_class sets err.

Structure
REQ-033 Shared package riscv_pkg holds:
- the six opcode constants;
- the op_class encoding;
- the FSM state typedef.
REQ-034 Sub-module instr_format (combinational field packer: class and fields in, 32-bit word and legal flag out) is instantiated once.

Verification
REQ-035 OPIMM, rd=1, rs1=0, funct3=0, imm=5 -> one cycle later imem_we=1, addr 0x0, wdata 0x00500093.
REQ-036 R, rd=3, rs1=1, rs2=2, funct3=0, funct7=0, then LOAD, rd=5, rs1=2, funct3=2, imm=4 -> words 0x002081B3 at 0x0 and 0x00412283 at 0x4.
REQ-037 BRANCH, rs1=1, rs2=2, funct3=0, imm=8, then JAL, rd=1, imm=16 -> 0x00208463 and 0x010000EF.
REQ-038 DEPTH=2, three back-to-back requests -> two writes, full=1, in_ready=0 on the third; start -> count=0, next write at 0x0.
REQ-039 op_class=7, then BRANCH imm=3 with ENCODER_RANGE_CHECK_EN defined -> err=1, no imem_we, count unchanged.
REQ-040 reset asserted in the WRITE cycle -> imem_we=0, count=0, state IDLE on the next cycle.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I encoding constants, request class encoding and encoder FSM state type.
package riscv_pkg;

   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   typedef enum logic [2:0] {
      CLS_R      = 3'd0,
      CLS_LOAD   = 3'd1,
      CLS_OPIMM  = 3'd2,
      CLS_STORE  = 3'd3,
      CLS_BRANCH = 3'd4,
      CLS_JAL    = 3'd5
   } op_class_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_FULL  = 2'd2
   } enc_state_e;

endpackage

// File: rtl/instr_format.sv
// Combinational RV32I field packer: request class and fields in, encoded word and legal flag out.
// Optional immediate range checking is enabled by defining ENCODER_RANGE_CHECK_EN.
module instr_format
   import riscv_pkg::*;
(
   input  logic [2:0]         op_class,
   input  logic [2:0]         funct3,
   input  logic [6:0]         funct7,
   input  logic [4:0]         rd,
   input  logic [4:0]         rs1,
   input  logic [4:0]         rs2,
   input  logic signed [20:0] imm,
   output logic [31:0]        word,
   output logic               legal
);

   logic cls_ok;
   logic imm_ok;

   always_comb begin
      word   = '0;
      cls_ok = 1'b1;
      case (op_class_e'(op_class))
         CLS_R:      word = {funct7, rs2, rs1, funct3, rd, OPC_R};
         CLS_LOAD:   word = {imm[11:0], rs1, funct3, rd, OPC_LOAD};
         CLS_OPIMM:  word = {imm[11:0], rs1, funct3, rd, OPC_OPIMM};
         CLS_STORE:  word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
         CLS_BRANCH: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPC_BRANCH};
         CLS_JAL:    word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
         default:    cls_ok = 1'b0;
      endcase
   end

`ifdef ENCODER_RANGE_CHECK_EN
   always_comb begin
      imm_ok = 1'b1;
      case (op_class_e'(op_class))
         CLS_LOAD, CLS_OPIMM, CLS_STORE:
            imm_ok = (imm >= -21'sd2048) && (imm <= 21'sd2047);
         CLS_BRANCH:
            imm_ok = (imm >= -21'sd4096) && (imm <= 21'sd4094) && !imm[0];
         CLS_JAL:
            imm_ok = !imm[0];
         default:
            imm_ok = 1'b1;
      endcase
   end
`else
   // Without range checking the byte-offset LSB is simply dropped.
   logic unused_imm0;
   assign unused_imm0 = imm[0];
   assign imm_ok      = 1'b1;
`endif

   assign legal = cls_ok && imm_ok;

endmodule

// File: rtl/instr_encoder.sv
// Encodes instruction requests into RV32I words and streams them into instruction memory.
// Define ENCODER_RANGE_CHECK_EN to reject out-of-range or misaligned immediates.
module instr_encoder
   import riscv_pkg::*;
#(
   parameter int          DEPTH     = 64,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [2:0]                   op_class,
   input  logic [2:0]                   funct3,
   input  logic [6:0]                   funct7,
   input  logic [4:0]                   rd,
   input  logic [4:0]                   rs1,
   input  logic [4:0]                   rs2,
   input  logic signed [20:0]           imm,
   input  logic                         start,
   output logic                         imem_we,
   output logic [31:0]                  imem_addr,
   output logic [31:0]                  imem_wdata,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         err
);

   localparam int CW = $clog2(DEPTH+1);

   enc_state_e    state, state_d;
   logic [31:0]   word_p0;
   logic          legal_p0;
   logic [31:0]   word_p1;
   logic          rewind_q;
   logic          rewind;
   logic          capture;
   logic          set_err;
   logic          cnt_inc;
   logic [CW-1:0] count_nxt;

   instr_format u_format (
      .op_class (op_class),
      .funct3   (funct3),
      .funct7   (funct7),
      .rd       (rd),
      .rs1      (rs1),
      .rs2      (rs2),
      .imm      (imm),
      .word     (word_p0),
      .legal    (legal_p0)
   );

   assign count_nxt = count + CW'(1);

   always_comb begin
      state_d  = state;
      in_ready = 1'b0;
      imem_we  = 1'b0;
      rewind   = 1'b0;
      capture  = 1'b0;
      set_err  = 1'b0;
      cnt_inc  = 1'b0;
      case (state)
         ST_IDLE: begin
            // A start seen during the previous WRITE is applied here, blocking new requests.
            rewind   = start || rewind_q;
            in_ready = !rewind;
            if (in_valid && in_ready) begin
               if (legal_p0) begin
                  capture = 1'b1;
                  state_d = ST_WRITE;
               end else begin
                  set_err = 1'b1;
               end
            end
         end
         ST_WRITE: begin
            imem_we = 1'b1;
            cnt_inc = 1'b1;
            state_d = (count_nxt == CW'(DEPTH)) ? ST_FULL : ST_IDLE;
         end
         ST_FULL: begin
            rewind = start || rewind_q;
            if (rewind) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Stage p0 -> p1: registered word drives memory during WRITE
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         count    <= '0;
         err      <= 1'b0;
         word_p1  <= '0;
         rewind_q <= 1'b0;
      end else begin
         state    <= state_d;
         rewind_q <= (state == ST_WRITE) && start;
         if (rewind) begin
            count <= '0;
            err   <= 1'b0;
         end else begin
            if (cnt_inc) count <= count_nxt;
            if (set_err) err   <= 1'b1;
         end
         if (capture) word_p1 <= word_p0;
      end
   end

   assign imem_wdata = word_p1;
   assign imem_addr  = BASE_ADDR + (32'(count) << 2);
   assign full       = (count == CW'(DEPTH));

endmodule

// File: tb/tb_instr_encoder.sv
// Table-driven bench with a write scoreboard for instr_encoder.
module tb_instr_encoder;

   localparam int          DEPTH = 16;
   localparam logic [31:0] BASE  = 32'h0000_0100;
   localparam int          CW    = $clog2(DEPTH+1);

   logic clk = 1'b0;
   logic reset, in_valid, start;
   logic in_ready;
   logic [2:0] op_class, funct3;
   logic [6:0] funct7;
   logic [4:0] rd, rs1, rs2;
   logic signed [20:0] imm;
   logic imem_we;
   logic [31:0] imem_addr, imem_wdata;
   logic [CW-1:0] count;
   logic full, err;

   always #5 clk = ~clk;

   instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .op_class(op_class), .funct3(funct3), .funct7(funct7), .rd(rd),
      .rs1(rs1), .rs2(rs2), .imm(imm), .start(start), .imem_we(imem_we),
      .imem_addr(imem_addr), .imem_wdata(imem_wdata), .count(count),
      .full(full), .err(err)
   );

   typedef struct {
      logic [2:0]  cls;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [20:0] imm;
      logic [31:0] word;
      bit          legal;
   } vec_t;

   vec_t tbl[11];
   logic [63:0] sb[$];
   int tests = 0;
   int fails = 0;
   int exp_count = 0;
   bit exp_err = 0;

   function automatic vec_t mk(input logic [2:0] c, input logic [2:0] f3, input logic [6:0] f7,
                               input logic [4:0] rd_, input logic [4:0] r1, input logic [4:0] r2,
                               input logic [20:0] im, input logic [31:0] w, input bit lg);
      vec_t v;
      v.cls = c; v.f3 = f3; v.f7 = f7; v.rd = rd_; v.rs1 = r1; v.rs2 = r2;
      v.imm = im; v.word = w; v.legal = lg;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Every memory write must match the oldest outstanding expected write.
   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h expected no write",
                     imem_addr, imem_wdata);
         end else begin
            logic [63:0] e;
            e = sb.pop_front();
            if ({imem_addr, imem_wdata} !== e) begin
               fails++;
               $display("FAIL write: got addr 0x%08h data 0x%08h expected addr 0x%08h data 0x%08h",
                        imem_addr, imem_wdata, e[63:32], e[31:0]);
            end
         end
      end
   end

   task automatic send(input vec_t v, input int bound, output bit acc);
      acc = 1'b0;
      @(negedge clk);
      op_class = v.cls; funct3 = v.f3; funct7 = v.f7; rd = v.rd;
      rs1 = v.rs1; rs2 = v.rs2; imm = v.imm; in_valid = 1'b1;
      for (int i = 0; i < bound; i++) begin
         if (in_ready === 1'b1) begin
            acc = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (acc) begin
         if (v.legal) begin
            sb.push_back({BASE + 32'(exp_count) * 32'd4, v.word});
            exp_count++;
         end else begin
            exp_err = 1'b1;
         end
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit acc;
      reset = 1'b1; in_valid = 1'b0; start = 1'b0;
      op_class = '0; funct3 = '0; funct7 = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;

      tbl[0]  = mk(3'd2, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 21'd5,       32'h00500093, 1);
      tbl[1]  = mk(3'd0, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 21'd0,       32'h002081B3, 1);
      tbl[2]  = mk(3'd1, 3'd2, 7'h00, 5'd5, 5'd2, 5'd0, 21'd4,       32'h00412283, 1);
      tbl[3]  = mk(3'd4, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 21'd8,       32'h00208463, 1);
      tbl[4]  = mk(3'd5, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 21'd16,      32'h010000EF, 1);
      tbl[5]  = mk(3'd3, 3'd2, 7'h00, 5'd0, 5'd2, 5'd3, 21'h1FFFFC,  32'hFE312E23, 1);
      tbl[6]  = mk(3'd7, 3'd0, 7'h00, 5'd1, 5'd1, 5'd1, 21'd1,       32'h00000000, 0);
`ifdef ENCODER_RANGE_CHECK_EN
      tbl[7]  = mk(3'd4, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 21'd3,       32'h00000000, 0);
      tbl[8]  = mk(3'd2, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 21'd2048,    32'h00000000, 0);
`else
      tbl[7]  = mk(3'd4, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 21'd3,       32'h00208163, 1);
      tbl[8]  = mk(3'd2, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 21'd2048,    32'h80000093, 1);
`endif
      tbl[9]  = mk(3'd5, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 21'h1FFFFE,  32'hFFFFF0EF, 1);
      tbl[10] = mk(3'd0, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 21'd0,       32'h402081B3, 1);

      repeat (3) @(posedge clk);
      #1;
      chk("reset_we",    32'(imem_we),  32'd0);
      chk("reset_wdata", imem_wdata,    32'd0);
      chk("reset_count", 32'(count),    32'd0);
      chk("reset_full",  32'(full),     32'd0);
      chk("reset_err",   32'(err),      32'd0);
      chk("reset_addr",  imem_addr,     BASE);
      reset = 1'b0;
      #1 chk("reset_ready", 32'(in_ready), 32'd1);

      // Main table: each entry is one request followed by its write cycle.
      for (int i = 0; i < 11; i++) begin
         send(tbl[i], 20, acc);
         chk($sformatf("accept_%0d", i), 32'(acc), 32'd1);
         @(posedge clk);
         #1;
         chk($sformatf("count_%0d", i), 32'(count), 32'(exp_count));
         chk($sformatf("err_%0d", i),   32'(err),   32'(exp_err));
      end

      // Start raised during WRITE: write finishes, rewind one cycle later.
      send(tbl[0], 20, acc);
      chk("wstart_accept", 32'(acc), 32'd1);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      chk("wstart_count_kept", 32'(count),    32'(exp_count));
      chk("wstart_ready_low",  32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      chk("wstart_count_zero", 32'(count),    32'd0);
      chk("wstart_err_clear",  32'(err),      32'd0);
      chk("wstart_ready",      32'(in_ready), 32'd1);
      exp_count = 0; exp_err = 0;

      // Fill to DEPTH with back-to-back requests.
      for (int i = 0; i < DEPTH; i++) begin
         send(tbl[i % 6], 20, acc);
         if (!acc) chk($sformatf("fill_accept_%0d", i), 32'(acc), 32'd1);
      end
      @(posedge clk);
      #1;
      chk("full_flag",  32'(full),     32'd1);
      chk("full_count", 32'(count),    32'(DEPTH));
      chk("full_ready", 32'(in_ready), 32'd0);
      send(tbl[0], 4, acc);
      chk("full_blocks", 32'(acc), 32'd0);
      chk("full_hold",   32'(count), 32'(DEPTH));

      // Start with a simultaneous request: request is not taken.
      @(negedge clk);
      start = 1'b1; in_valid = 1'b1;
      #1 chk("start_ready_low", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1 start = 1'b0; in_valid = 1'b0;
      chk("start_count", 32'(count), 32'd0);
      chk("start_full",  32'(full),  32'd0);
      exp_count = 0;
      send(tbl[1], 20, acc);
      chk("restart_accept", 32'(acc), 32'd1);
      @(posedge clk);
      #1 chk("restart_count", 32'(count), 32'd1);

      // Illegal class after restart: sticky err, no write, count unchanged.
      send(tbl[6], 20, acc);
      @(posedge clk);
      #1;
      chk("illegal_err",   32'(err),   32'd1);
      chk("illegal_count", 32'(count), 32'd1);

      // Reset in the WRITE cycle aborts the state machine.
      send(tbl[2], 20, acc);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_write_we",    32'(imem_we),  32'd0);
      chk("rst_write_count", 32'(count),    32'd0);
      chk("rst_write_ready", 32'(in_ready), 32'd1);
      chk("rst_write_err",   32'(err),      32'd0);
      exp_count = 0; exp_err = 0;

      repeat (3) @(posedge clk);
      #1 chk("pending_writes", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
